// File: rtl/ctrl_cfg_decoder_pkg.sv
// Shared definitions for the control-packet configuration decoder:
// header byte offsets, control port, error codes and FSM encoding.
package ctrl_cfg_decoder_pkg;

  localparam int unsigned HDR_MODULE_BYTE   = 42;
  localparam int unsigned HDR_RESOURCE_BYTE = 43;
  localparam int unsigned HDR_IDX_HI_BYTE   = 44;
  localparam int unsigned HDR_IDX_LO_BYTE   = 45;
  localparam int unsigned HDR_NUM_BYTE      = 46;

  localparam logic [15:0] CTRL_UDP_PORT = 16'hf1f2;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_MODULE = 2'd1;
  localparam logic [1:0] ERR_ZERO_COUNT = 2'd2;
  localparam logic [1:0] ERR_SHORT_PKT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_cfg_hdr_parse.sv
// Combinational extraction of the control header fields and header validity check.
module ctrl_cfg_hdr_parse
  import ctrl_cfg_decoder_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 512,
  parameter int unsigned C_NUM_STAGES        = 5
) (
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
  input  logic                           tlast,
  output logic [7:0]                     module_id,
  output logic [7:0]                     resource_id,
  output logic [15:0]                    start_idx,
  output logic [7:0]                     num_entries,
  output logic                           hdr_ok,
  output logic [1:0]                     hdr_err
);

  logic unused_tdata;
  assign unused_tdata = ^tdata;

  assign module_id   = tdata[8*HDR_MODULE_BYTE +: 8];
  assign resource_id = tdata[8*HDR_RESOURCE_BYTE +: 8];
  assign start_idx   = {tdata[8*HDR_IDX_HI_BYTE +: 8], tdata[8*HDR_IDX_LO_BYTE +: 8]};
  assign num_entries = tdata[8*HDR_NUM_BYTE +: 8];

  // Priority: bad module, then zero count, then a header that is also the last beat.
  always_comb begin
    hdr_err = ERR_NONE;
    if ({24'd0, module_id} >= C_NUM_STAGES) begin
      hdr_err = ERR_BAD_MODULE;
    end else if (num_entries == 8'd0) begin
      hdr_err = ERR_ZERO_COUNT;
    end else if (tlast) begin
      hdr_err = ERR_SHORT_PKT;
    end
  end

  assign hdr_ok = (hdr_err == ERR_NONE);

endmodule

// File: rtl/ctrl_cfg_decoder.sv
// Turns control packets into registered per-entry configuration writes.
// Optional statistics counters enabled by defining CTRL_CFG_DECODER_STATS_EN.
module ctrl_cfg_decoder
  import ctrl_cfg_decoder_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_STAGES         = 5
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   c_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] c_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]  c_s_axis_tuser,
  input  logic                             c_s_axis_tvalid,
  input  logic                             c_s_axis_tlast,
  output logic                             cfg_wr_valid,
  output logic [7:0]                       cfg_wr_module,
  output logic [7:0]                       cfg_wr_resource,
  output logic [15:0]                      cfg_wr_index,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]   cfg_wr_data,
  output logic                             cfg_wr_last,
  output logic                             cfg_err,
  output logic [1:0]                       cfg_err_code
`ifdef CTRL_CFG_DECODER_STATS_EN
  ,
  output logic [31:0]                      cfg_pkt_cnt,
  output logic [31:0]                      cfg_err_cnt
`endif
);

  state_t state, state_nxt;

  logic [7:0]  hdr_module, hdr_resource, hdr_num;
  logic [15:0] hdr_idx;
  logic        hdr_ok;
  logic [1:0]  hdr_err;

  logic [7:0]  mod_q, res_q, rem_q;
  logic [15:0] idx_q;

  logic        wr_fire, err_fire, hdr_accept;
  logic [1:0]  err_code_nxt;
  logic [C_S_AXIS_DATA_WIDTH-1:0] data_masked;

  logic unused_tuser;
  assign unused_tuser = ^c_s_axis_tuser;

  ctrl_cfg_hdr_parse #(
    .C_S_AXIS_DATA_WIDTH(C_S_AXIS_DATA_WIDTH),
    .C_NUM_STAGES       (C_NUM_STAGES)
  ) u_hdr_parse (
    .tdata      (c_s_axis_tdata),
    .tlast      (c_s_axis_tlast),
    .module_id  (hdr_module),
    .resource_id(hdr_resource),
    .start_idx  (hdr_idx),
    .num_entries(hdr_num),
    .hdr_ok     (hdr_ok),
    .hdr_err    (hdr_err)
  );

  always_ff @(posedge clk) begin
    if (aresetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // A rejected header without tlast still owns the rest of its packet, hence DISCARD.
  always_comb begin
    state_nxt = state;
    if (c_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (hdr_ok)               state_nxt = ST_PAYLOAD;
          else if (!c_s_axis_tlast) state_nxt = ST_DISCARD;
        end
        ST_PAYLOAD: if (c_s_axis_tlast) state_nxt = ST_IDLE;
        ST_DISCARD: if (c_s_axis_tlast) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_fire      = 1'b0;
    err_fire     = 1'b0;
    hdr_accept   = 1'b0;
    err_code_nxt = ERR_NONE;
    if (c_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          hdr_accept   = hdr_ok;
          err_fire     = !hdr_ok;
          err_code_nxt = hdr_err;
        end
        ST_PAYLOAD: begin
          wr_fire = (rem_q != 8'd0);
          if (c_s_axis_tlast && (rem_q > 8'd1)) begin
            err_fire     = 1'b1;
            err_code_nxt = ERR_SHORT_PKT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_masked = '0;
    for (int unsigned k = 0; k < C_S_AXIS_DATA_WIDTH/8; k++) begin
      data_masked[8*k +: 8] = c_s_axis_tkeep[k] ? c_s_axis_tdata[8*k +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      mod_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
    end else if (hdr_accept) begin
      mod_q <= hdr_module;
      res_q <= hdr_resource;
      idx_q <= hdr_idx;
      rem_q <= hdr_num;
    end else if (wr_fire) begin
      idx_q <= idx_q + 16'd1;
      rem_q <= rem_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      cfg_wr_valid    <= 1'b0;
      cfg_wr_module   <= '0;
      cfg_wr_resource <= '0;
      cfg_wr_index    <= '0;
      cfg_wr_data     <= '0;
      cfg_wr_last     <= 1'b0;
      cfg_err         <= 1'b0;
      cfg_err_code    <= '0;
    end else begin
      cfg_wr_valid <= wr_fire;
      cfg_err      <= err_fire;
      if (wr_fire) begin
        cfg_wr_module   <= mod_q;
        cfg_wr_resource <= res_q;
        cfg_wr_index    <= idx_q;
        cfg_wr_data     <= data_masked;
        cfg_wr_last     <= (rem_q == 8'd1);
      end
      if (err_fire) cfg_err_code <= err_code_nxt;
    end
  end

`ifdef CTRL_CFG_DECODER_STATS_EN
  // first_q marks an accepted header whose packet has not yet produced a write.
  logic first_q;

  always_ff @(posedge clk) begin
    if (aresetn) begin
      first_q     <= 1'b0;
      cfg_pkt_cnt <= '0;
      cfg_err_cnt <= '0;
    end else begin
      if (hdr_accept)   first_q <= 1'b1;
      else if (wr_fire) first_q <= 1'b0;
      if (wr_fire && first_q) cfg_pkt_cnt <= sat_inc(cfg_pkt_cnt);
      if (err_fire)           cfg_err_cnt <= sat_inc(cfg_err_cnt);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_cfg_decoder.sv
// Directed bench for ctrl_cfg_decoder with a packet-level expectation model and per-cycle compare.
module tb_ctrl_cfg_decoder;
  import ctrl_cfg_decoder_pkg::*;

  logic         clk = 1'b0;
  logic         aresetn = 1'b1;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic [127:0] tuser = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         wr_valid, wr_last, err;
  logic [7:0]   wr_module, wr_resource;
  logic [15:0]  wr_index;
  logic [511:0] wr_data;
  logic [1:0]   err_code;
`ifdef CTRL_CFG_DECODER_STATS_EN
  logic [31:0]  pkt_cnt, err_cnt;
`endif

  ctrl_cfg_decoder #(
    .C_S_AXIS_DATA_WIDTH (512),
    .C_S_AXIS_TUSER_WIDTH(128),
    .C_NUM_STAGES        (5)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .c_s_axis_tdata (tdata),
    .c_s_axis_tkeep (tkeep),
    .c_s_axis_tuser (tuser),
    .c_s_axis_tvalid(tvalid),
    .c_s_axis_tlast (tlast),
    .cfg_wr_valid   (wr_valid),
    .cfg_wr_module  (wr_module),
    .cfg_wr_resource(wr_resource),
    .cfg_wr_index   (wr_index),
    .cfg_wr_data    (wr_data),
    .cfg_wr_last    (wr_last),
    .cfg_err        (err),
    .cfg_err_code   (err_code)
`ifdef CTRL_CFG_DECODER_STATS_EN
    ,
    .cfg_pkt_cnt    (pkt_cnt),
    .cfg_err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   m;
    logic [7:0]   r;
    logic [15:0]  i;
    logic [511:0] d;
    logic         l;
  } wr_t;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int m_pkt = 0;
  int m_err = 0;

  wr_t        exp_wr[int];
  logic [1:0] exp_err[int];
  wr_t        obs_wr[$];
  logic [1:0] obs_err[$];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h want=%0h", name, edge_n, got, want);
    end
  endtask

  function automatic logic [511:0] mask_bytes(input logic [511:0] d, input logic [63:0] k);
    logic [511:0] r;
    r = '0;
    for (int b = 0; b < 64; b++) if (k[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Per-cycle compare: outputs sampled 1 time unit after each rising edge.
  initial begin
    wr_t        cur;
    logic [1:0] cur_code;
    cur = '{default: '0};
    cur_code = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      if (wr_valid === 1'b1) obs_wr.push_back('{wr_module, wr_resource, wr_index, wr_data, wr_last});
      if (err === 1'b1) obs_err.push_back(err_code);
      if (aresetn) begin
        cur = '{default: '0};
        cur_code = 2'd0;
        chk("rst_wr_valid", 512'(wr_valid), 512'd0);
        chk("rst_wr_last", 512'(wr_last), 512'd0);
        chk("rst_err", 512'(err), 512'd0);
      end else begin
        if (exp_wr.exists(edge_n)) begin
          cur = exp_wr[edge_n];
          chk("wr_valid", 512'(wr_valid), 512'd1);
          chk("wr_last", 512'(wr_last), 512'(cur.l));
        end else begin
          chk("wr_valid_idle", 512'(wr_valid), 512'd0);
        end
        if (exp_err.exists(edge_n)) begin
          cur_code = exp_err[edge_n];
          chk("err", 512'(err), 512'd1);
        end else begin
          chk("err_idle", 512'(err), 512'd0);
        end
      end
      chk("wr_module", 512'(wr_module), 512'(cur.m));
      chk("wr_resource", 512'(wr_resource), 512'(cur.r));
      chk("wr_index", 512'(wr_index), 512'(cur.i));
      chk("wr_data", wr_data, cur.d);
      chk("err_code", 512'(err_code), 512'(cur_code));
    end
  end

  // Drives one cycle of input at the falling edge; e is the rising edge that samples it.
  task automatic drive(input logic v, input logic [511:0] d, input logic [63:0] k,
                       input logic l, output int e);
    @(negedge clk);
    tvalid = v;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    e = edge_n + 1;
  endtask

  task automatic idle(input int n);
    int e;
    for (int c = 0; c < n; c++) drive(1'b0, '0, '0, 1'b0, e);
  endtask

  task automatic do_reset(input int n);
    int e;
    @(negedge clk);
    aresetn = 1'b1;
    for (int c = 0; c < n; c++) drive(1'b0, '0, '0, 1'b0, e);
    @(negedge clk);
    aresetn = 1'b0;
    m_pkt = 0;
    m_err = 0;
  endtask

  // Sends header + npay payload beats and records what the stream must produce.
  task automatic send_packet(input int mod, input int res, input int idx, input int n,
                             input int npay, input logic [63:0] last_keep,
                             input logic [7:0] gaps, input logic with_last);
    logic [511:0] h, d;
    logic [63:0]  k;
    logic [31:0]  w;
    logic [15:0]  wi;
    logic         l, good;
    int           e;
    h = {64{8'h5A}};
    h[8*42 +: 8] = 8'(mod);
    h[8*43 +: 8] = 8'(res);
    h[8*44 +: 8] = 8'(idx >> 8);
    h[8*45 +: 8] = 8'(idx);
    h[8*46 +: 8] = 8'(n);
    drive(1'b1, h, '1, with_last && (npay == 0), e);
    good = 1'b0;
    if (mod >= 5) exp_err[e] = 2'd1;
    else if (n == 0) exp_err[e] = 2'd2;
    else if (npay == 0 && with_last) exp_err[e] = 2'd3;
    else good = 1'b1;
    if (!good) m_err++;
    else if (npay > 0) m_pkt++;
    for (int j = 0; j < npay; j++) begin
      w = {8'(mod), 8'(res), 16'(j * 37 + 1)};
      d = {16{w}};
      if (gaps[j]) drive(1'b0, ~d, '1, 1'b1, e);
      l = with_last && (j == npay - 1);
      k = (j == npay - 1) ? last_keep : '1;
      drive(1'b1, d, k, l, e);
      if (good && j < n) begin
        wi = 16'(idx + j);
        exp_wr[e] = '{8'(mod), 8'(res), wi, mask_bytes(d, k), (j == n - 1)};
        if (l && j < n - 1) begin
          exp_err[e] = 2'd3;
          m_err++;
        end
      end
    end
  endtask

  initial begin
    do_reset(3);
    idle(2);

    // Nominal 3-entry packet.
    obs_wr.delete(); obs_err.delete();
    send_packet(2, 1, 16'h0010, 3, 3, '1, 8'h00, 1'b1);
    idle(3);
    chk("t1_nwr", 512'(obs_wr.size()), 512'd3);
    if (obs_wr.size() == 3) begin
      chk("t1_idx0", 512'(obs_wr[0].i), 512'h10);
      chk("t1_idx2", 512'(obs_wr[2].i), 512'h12);
      chk("t1_last1", 512'(obs_wr[1].l), 512'd0);
      chk("t1_last2", 512'(obs_wr[2].l), 512'd1);
      chk("t1_mod", 512'(obs_wr[0].m), 512'd2);
    end
    chk("t1_nerr", 512'(obs_err.size()), 512'd0);

    // Bad module, 4-beat packet, then a good one.
    obs_wr.delete(); obs_err.delete();
    send_packet(7, 0, 16'h0000, 2, 3, '1, 8'h00, 1'b1);
    idle(2);
    chk("t2_nwr", 512'(obs_wr.size()), 512'd0);
    chk("t2_nerr", 512'(obs_err.size()), 512'd1);
    if (obs_err.size() == 1) chk("t2_code", 512'(obs_err[0]), 512'd1);
    obs_wr.delete();
    send_packet(1, 4, 16'h0200, 1, 1, '1, 8'h00, 1'b1);
    idle(2);
    chk("t2b_nwr", 512'(obs_wr.size()), 512'd1);
    if (obs_wr.size() == 1) begin
      chk("t2b_idx", 512'(obs_wr[0].i), 512'h200);
      chk("t2b_last", 512'(obs_wr[0].l), 512'd1);
    end

    // Short packet: 4 entries announced, 2 delivered.
    obs_wr.delete(); obs_err.delete();
    send_packet(0, 2, 16'h0030, 4, 2, '1, 8'h00, 1'b1);
    idle(2);
    chk("t3_nwr", 512'(obs_wr.size()), 512'd2);
    if (obs_wr.size() == 2) chk("t3_nolast", 512'({obs_wr[0].l, obs_wr[1].l}), 512'd0);
    chk("t3_nerr", 512'(obs_err.size()), 512'd1);
    if (obs_err.size() == 1) chk("t3_code", 512'(obs_err[0]), 512'd3);

    // Index wrap with a partial keep on the last beat.
    obs_wr.delete(); obs_err.delete();
    send_packet(4, 9, 16'hFFFF, 2, 2, 64'h0000_0000_0000_00FF, 8'h00, 1'b1);
    idle(2);
    chk("t4_nwr", 512'(obs_wr.size()), 512'd2);
    if (obs_wr.size() == 2) begin
      chk("t4_idx0", 512'(obs_wr[0].i), 512'hFFFF);
      chk("t4_idx1", 512'(obs_wr[1].i), 512'h0000);
      chk("t4_hi_zero", 512'(obs_wr[1].d[511:64]), 512'd0);
      chk("t4_lo", 512'(obs_wr[1].d[63:0]), 512'h0409_0026_0409_0026);
    end

    // Gapped packet, back-to-back packet, then reset mid-payload.
    obs_wr.delete(); obs_err.delete();
    send_packet(3, 3, 16'h0100, 3, 3, '1, 8'b0000_0101, 1'b1);
    send_packet(1, 1, 16'h0007, 2, 2, '1, 8'h00, 1'b1);
    send_packet(2, 2, 16'h0050, 5, 1, '1, 8'h00, 1'b0);
    do_reset(2);
    @(posedge clk);
    #2;
    chk("t5_fsm_idle", 512'(dut.state), 512'(ST_IDLE));
    chk("t5_nwr", 512'(obs_wr.size()), 512'd6);
    if (obs_wr.size() == 6) begin
      chk("t5_idx2", 512'(obs_wr[2].i), 512'h102);
      chk("t5_idx4", 512'(obs_wr[4].i), 512'h008);
    end
    chk("t5_rst_data", wr_data, 512'd0);
    chk("t5_rst_code", 512'(err_code), 512'd0);

    // Post-reset mix: 3 good packets, 2 errored ones.
    obs_wr.delete(); obs_err.delete();
    send_packet(0, 5, 16'h1234, 2, 2, '1, 8'h00, 1'b1);
    send_packet(0, 0, 16'h0001, 0, 1, '1, 8'h00, 1'b1);
    send_packet(9, 0, 16'h0001, 1, 0, '1, 8'h00, 1'b1);
    send_packet(4, 6, 16'h0040, 1, 2, '1, 8'h00, 1'b1);
    send_packet(3, 7, 16'h0300, 2, 2, '1, 8'h00, 1'b1);
    idle(3);
    chk("t6_nwr", 512'(obs_wr.size()), 512'd5);
    chk("t6_nerr", 512'(obs_err.size()), 512'd2);
    if (obs_err.size() == 2) chk("t6_codes", 512'({obs_err[0], obs_err[1]}), 512'b1001);
`ifdef CTRL_CFG_DECODER_STATS_EN
    chk("pkt_cnt", 512'(pkt_cnt), 512'(m_pkt));
    chk("err_cnt", 512'(err_cnt), 512'(m_err));
    chk("pkt_cnt_lit", 512'(pkt_cnt), 512'd3);
    chk("err_cnt_lit", 512'(err_cnt), 512'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
